// File: rtl/conv_pkg.sv
// Shared constants, output-count helpers and FSM state type for the sliding-window generator.
package conv_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } win_state_e;

    function automatic int pix_w(input int i_width, input int channels);
        return i_width * channels;
    endfunction

    // Output positions along one axis of length n for filter f and stride s
    function automatic int out_dim(input int n, input int f, input int s);
        return (n - f) / s + 1;
    endfunction

    function automatic int out_count(input int w, input int h, input int f, input int s);
        return out_dim(w, f, s) * out_dim(h, f, s);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Cascade of LINES row delays, DEPTH pixels each; taps[l] is the pixel l+1 rows above din.
module line_buffer #(
    parameter int PIX_W = 24,
    parameter int DEPTH = 64,
    parameter int LINES = 4
) (
    input  logic                        clk,
    input  logic                        shift_en,
    input  logic [PIX_W-1:0]            din,
    output logic [LINES-1:0][PIX_W-1:0] taps
);

    for (genvar l = 0; l < LINES; l++) begin : g_line
        logic [DEPTH-1:0][PIX_W-1:0] mem;
        logic [PIX_W-1:0]            lin;

        if (l == 0) begin : g_head
            assign lin = din;
        end else begin : g_chain
            assign lin = taps[l-1];
        end

        // Storage is intentionally unreset; emission gating hides stale contents.
        always_ff @(posedge clk) begin
            if (shift_en) mem <= {mem[DEPTH-2:0], lin};
        end

        assign taps[l] = mem[DEPTH-1];
    end

endmodule

// File: rtl/conv_window_generator.sv
// Streaming FxFxC window generator with strided emission and frame-end flag.
// Optional CONV_WINDOW_COORD_EN adds registered output-grid coordinates out_row/out_col.
module conv_window_generator
    import conv_pkg::*;
#(
    parameter int I_WIDTH      = 8,
    parameter int CHANNELS_IN  = 3,
    parameter int FILTER_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int STRIDE       = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   clk_en,
    input  logic                                                   in_valid,
    input  logic [CHANNELS_IN*I_WIDTH-1:0]                         input_data,
    output logic [FILTER_SIZE*FILTER_SIZE*CHANNELS_IN*I_WIDTH-1:0] window_data,
    output logic                                                   valid,
    output logic                                                   frame_done
`ifdef CONV_WINDOW_COORD_EN
    ,
    output logic [15:0]                                            out_row,
    output logic [15:0]                                            out_col
`endif
);

    localparam int F      = FILTER_SIZE;
    localparam int PIX_W  = pix_w(I_WIDTH, CHANNELS_IN);
    localparam int WIN_N  = F * F;
    localparam int CW     = $clog2(IMAGE_WIDTH);
    localparam int RW     = $clog2(IMAGE_HEIGHT);
    localparam int PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int LAST_C = F - 1 + (out_dim(IMAGE_WIDTH, F, STRIDE) - 1) * STRIDE;
    localparam int LAST_R = F - 1 + (out_dim(IMAGE_HEIGHT, F, STRIDE) - 1) * STRIDE;

    localparam logic [CW-1:0] C_MAX      = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] C_FIRST    = CW'(F - 1);
    localparam logic [CW-1:0] C_LAST     = CW'(LAST_C);
    localparam logic [RW-1:0] R_MAX      = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] R_FILL_END = RW'(F - 2);
    localparam logic [RW-1:0] R_LAST     = RW'(LAST_R);
    localparam logic [PW-1:0] PH_MAX     = PW'(STRIDE - 1);

    logic                            accept;
    logic [CW-1:0]                   col_q;
    logic [RW-1:0]                   row_q;
    logic [PW-1:0]                   col_ph_q, row_ph_q;
    win_state_e                      state_q, state_d;
    logic                            col_end, row_end, col_in_win;
    logic                            col_hit, row_hit, emit, last_pos;
    logic [F-2:0][PIX_W-1:0]         taps;
    logic [WIN_N-1:0][PIX_W-1:0]     win_q, win_d, win_out_q;

    assign accept     = clk_en & in_valid;
    assign col_end    = (col_q == C_MAX);
    assign row_end    = (row_q == R_MAX);
    assign col_in_win = (col_q >= C_FIRST);
    assign col_hit    = col_in_win && (col_ph_q == '0);
    assign row_hit    = (state_q == ACTIVE) && (row_ph_q == '0);
    assign emit       = accept && row_hit && col_hit;
    assign last_pos   = (row_q == R_LAST) && (col_q == C_LAST);

    line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMAGE_WIDTH),
        .LINES (F - 1)
    ) u_line_buffer (
        .clk      (clk),
        .shift_en (accept),
        .din      (input_data),
        .taps     (taps)
    );

    // Raster position and stride phases; phases only advance inside the window region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_q    <= '0;
                col_ph_q <= '0;
                if (row_end) begin
                    row_q    <= '0;
                    row_ph_q <= '0;
                end else begin
                    row_q <= row_q + 1'b1;
                    if (state_q == ACTIVE)
                        row_ph_q <= (row_ph_q == PH_MAX) ? '0 : row_ph_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
                if (col_in_win)
                    col_ph_q <= (col_ph_q == PH_MAX) ? '0 : col_ph_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && col_end && (row_q == R_FILL_END)) state_d = ACTIVE;
            ACTIVE:  if (accept && col_end && row_end)               state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Shift the window left; the new right column is the line-buffer taps over input_data.
    always_comb begin
        win_d = win_q;
        for (int ky = 0; ky < F; ky++) begin
            for (int kx = 0; kx < F - 1; kx++)
                win_d[ky*F+kx] = win_q[ky*F+kx+1];
        end
        for (int ky = 0; ky < F - 1; ky++)
            win_d[ky*F+F-1] = taps[F-2-ky];
        win_d[WIN_N-1] = input_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      win_q <= '0;
        else if (accept) win_q <= win_d;
    end

`ifdef CONV_WINDOW_COORD_EN
    logic [15:0] oc_q, or_q;

    // Counts of emitting columns in this row and emitting rows in this frame so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc_q <= '0;
            or_q <= '0;
        end else if (accept) begin
            if (col_end) begin
                oc_q <= '0;
                if (row_end)      or_q <= '0;
                else if (row_hit) or_q <= or_q + 1'b1;
            end else if (col_hit) begin
                oc_q <= oc_q + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            win_out_q  <= '0;
`ifdef CONV_WINDOW_COORD_EN
            out_row    <= '0;
            out_col    <= '0;
`endif
        end else if (clk_en) begin
            valid      <= emit;
            frame_done <= emit && last_pos;
            if (emit) begin
                win_out_q <= win_d;
`ifdef CONV_WINDOW_COORD_EN
                out_row   <= or_q;
                out_col   <= oc_q;
`endif
            end
        end
    end

    assign window_data = win_out_q;

endmodule
